// File: rtl/ps2_kbd_mmio_if.sv
// CPU data-bus slice for the PS/2 keyboard window.
//
// Handshake: cpu_rd is a single-cycle strobe. The address decode is already
// done upstream. The slave always accepts it, so there is no ready signal.
// The response is valid on cpu_rdata from the next rising edge. It holds
// until the next strobe.
interface ps2_kbd_mmio_if;
  logic        cpu_rd;
  logic [2:0]  cpu_addr;
  logic [31:0] cpu_rdata;

  modport master (output cpu_rd, output cpu_addr, input cpu_rdata);
  modport slave  (input cpu_rd, input cpu_addr, output cpu_rdata);
endinterface

// File: rtl/ps2_kbd_mmio.sv
// PS/2 keyboard receiver mapped onto the CPU data bus.
// It deserialises and checks PS/2 frames, and queues good scan codes in a FIFO.
// It serves DATA and STATUS reads, and flags pending data to the core.
module ps2_kbd_mmio #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_kbd_mmio_if.slave  bus,
  output logic           kbd_pending,
  output logic [1:0]     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall;
  logic [2:0]             bitcnt;
  logic [7:0]             sreg;
  logic                   par;
  logic [TW-1:0]          idle_cnt;
  logic                   timeout_hit;
  logic                   frame_done, frame_good, err_inc;
  logic                   push_req;
  logic [7:0]             push_byte;
  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic [7:0]             err_cnt;
  logic                   rd_data, rd_status, nonempty, full;
  logic                   do_pop, do_push, drop;
  logic [31:0]            status_word;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Bring the pad signals into the clock domain; idle level of the bus is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  // Abandon a partial frame after TIMEOUT cycles with no PS/2 falling edge.
  assign timeout_hit = (state != S_IDLE) && !fall && (idle_cnt == TW'(TIMEOUT - 1));

  // Count quiet cycles while a frame is in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (fall || state == S_IDLE || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Frame next-state: advance on falling edges, judge the frame at the stop bit.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    frame_good = 1'b0;
    if (timeout_hit) begin
      state_next = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!data_s) state_next = S_SHIFT;
        S_SHIFT:  if (bitcnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          frame_done = 1'b1;
          frame_good = data_s & (^sreg ^ par);
          state_next = S_IDLE;
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  assign err_inc = (frame_done & ~frame_good) | timeout_hit;

  // Shift register, bit counter and parity capture; bits arrive LSB first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitcnt <= 3'd0;
      sreg   <= 8'd0;
      par    <= 1'b0;
    end else if (fall) begin
      case (state)
        S_IDLE:   bitcnt <= 3'd0;
        S_SHIFT: begin
          sreg   <= {data_s, sreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
        end
        S_PARITY: par <= data_s;
        default:  ;
      endcase
    end
  end

  // A good frame becomes a push request on the following cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      push_req  <= 1'b0;
      push_byte <= 8'd0;
    end else begin
      push_req  <= frame_done & frame_good;
      push_byte <= sreg;
    end
  end

  assign rd_data   = bus.cpu_rd && (bus.cpu_addr == 3'd0);
  assign rd_status = bus.cpu_rd && (bus.cpu_addr == 3'd4);
  assign nonempty  = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = rd_data & nonempty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push   = push_req & (~full | do_pop);
  assign drop      = push_req & full & ~do_pop;

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating error counter, cleared by a STATUS read.
  // A new event in the read cycle is kept rather than lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (rd_status) overflow <= 1'b0;
      if (rd_status)                       err_cnt <= err_inc ? 8'd1 : 8'd0;
      else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign status_word = {16'b0, err_cnt, 1'b0, 4'(count), overflow, full, nonempty};

  // Registered read data; it holds between strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.cpu_rdata <= 32'd0;
    end else if (bus.cpu_rd) begin
      if (rd_data)        bus.cpu_rdata <= nonempty ? {24'b0, mem[rd_ptr]} : 32'd0;
      else if (rd_status) bus.cpu_rdata <= status_word;
      else                bus.cpu_rdata <= 32'd0;
    end
  end

  assign kbd_pending = nonempty;
  assign dbg_state   = state;

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// Bench for ps2_kbd_mmio. The driver tasks bit-bang PS/2 frames and issue bus
// reads. A queue model predicts every read response. A monitor pops the
// predictions and compares them against cpu_rdata.
module tb_ps2_kbd_mmio;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;

  logic        clock;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic        kbd_pending;
  logic [1:0]  dbg_state;

  ps2_kbd_mmio_if bus();

  ps2_kbd_mmio #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .bus         (bus),
    .kbd_pending (kbd_pending),
    .dbg_state   (dbg_state)
  );

  // Clock block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  // Reference model: the keyboard FIFO as a byte queue plus flags.
  logic [7:0] m_q[$];
  logic [7:0] m_err;
  logic       m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_err = 8'd0;
    m_ovf = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (good) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovf = 1'b1;
    end else if (m_err != 8'hFF) begin
      m_err = m_err + 8'd1;
    end
  endtask

  task automatic model_read(input logic [2:0] a, output logic [31:0] v);
    v = 32'd0;
    if (a == 3'd0) begin
      if (m_q.size() != 0) v = {24'b0, m_q.pop_front()};
    end else if (a == 3'd4) begin
      v = {16'b0, m_err, 1'b0, 4'(m_q.size()), m_ovf,
           (m_q.size() == DEPTH), (m_q.size() != 0)};
      m_err = 8'd0;
      m_ovf = 1'b0;
    end
  endtask

  // Driver: one PS/2 bit. Data changes while the clock is high. With coincide
  // set, a DATA read is issued so that it lands on the FIFO push cycle.
  task automatic ps2_bit(input logic b, input bit coincide);
    logic [31:0] e;
    @(negedge clock);
    ps2_data = b;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clock);
      if (coincide && i == 3) begin
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 3'd0;
        model_read(3'd0, e);
        exp_q.push_back(e);
      end
      if (coincide && i == 4) bus.cpu_rd = 1'b0;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input bit stop, input bit coincide);
    logic p;
    p = ~(^b) ^ flip_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(stop, coincide);
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clock);
    model_frame(b, !flip_par && stop);
  endtask

  task automatic send_bits(input int n);
    ps2_bit(1'b0, 1'b0);
    for (int i = 1; i < n; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    @(negedge clock);
    ps2_data = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a);
    logic [31:0] e;
    @(negedge clock);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = a;
    model_read(a, e);
    exp_q.push_back(e);
    @(negedge clock);
    bus.cpu_rd = 1'b0;
  endtask

  // Monitor: each strobe produces a response one edge later.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clock);
      if (bus.cpu_rd === 1'b1) begin
        @(negedge clock);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got %h with nothing expected", bus.cpu_rdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.cpu_rdata !== e) begin
            bad++;
            $display("FAIL rdata: got %h expected %h", bus.cpu_rdata, e);
          end
        end
      end
    end
  end

  initial begin
    int act;
    logic [2:0] oa [6];
    oa[0] = 3'd1; oa[1] = 3'd2; oa[2] = 3'd3; oa[3] = 3'd5; oa[4] = 3'd6; oa[5] = 3'd7;

    // Reset block.
    reset        = 1'b0;
    ps2_clk      = 1'b1;
    ps2_data     = 1'b1;
    bus.cpu_rd   = 1'b0;
    bus.cpu_addr = 3'd0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_rdata", bus.cpu_rdata, 32'd0);
    check("reset_pending", {31'b0, kbd_pending}, 32'd0);
    check("reset_state", {30'b0, dbg_state}, 32'd0);
    cpu_read(3'd4);

    // Single good frame.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("pending_after_1c", {31'b0, kbd_pending}, 32'd1);
    cpu_read(3'd0);
    cpu_read(3'd4);

    // Parity error and framing error.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("pending_after_errs", {31'b0, kbd_pending}, 32'd0);
    cpu_read(3'd4);
    cpu_read(3'd4);

    // Overflow: nine frames into eight slots.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    cpu_read(3'd4);
    for (int i = 0; i < 9; i++) cpu_read(3'd0);
    check("pending_drained", {31'b0, kbd_pending}, 32'd0);

    // Partial frame abandoned by the timeout, then a clean frame.
    send_bits(5);
    repeat (TIMEOUT + 20) @(negedge clock);
    model_frame(8'h00, 1'b0);
    check("state_after_timeout", {30'b0, dbg_state}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    cpu_read(3'd4);
    cpu_read(3'd0);

    // Seven entries, then a push that coincides with a DATA read.
    for (int i = 0; i < 7; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
    send_frame(8'hA7, 1'b0, 1'b1, 1'b1);
    cpu_read(3'd4);
    for (int i = 0; i < 8; i++) cpu_read(3'd0);

    // Randomised mix of frames and reads.
    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 6);
      case (act)
        0, 1: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
        2:    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
        3:    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        4:    cpu_read(3'd0);
        5:    cpu_read(3'd4);
        default: cpu_read(oa[$urandom_range(0, 5)]);
      endcase
      check("pending_model", {31'b0, kbd_pending}, {31'b0, (m_q.size() != 0)});
    end

    // Reset in the middle of a frame.
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    cpu_read(3'd4);
    send_bits(4);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset_rdata", bus.cpu_rdata, 32'd0);
    check("midreset_pending", {31'b0, kbd_pending}, 32'd0);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    send_frame(8'h77, 1'b0, 1'b1, 1'b0);
    cpu_read(3'd4);
    cpu_read(3'd0);
    cpu_read(3'd0);

    // Wait, with a bound, for outstanding responses.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
